// File: rtl/dmem_bus_responder.sv
// rtl/dmem_bus_responder.sv - data-memory responder with wait states, RV32I lanes and error response
module dmem_bus_responder #(
    parameter int DEPTH_WORDS    = 128,
    parameter int WAIT_STATES    = 1,
    parameter int MISALIGNED_ERR = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [2:0]  req_width_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int         AW   = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS   = 4'(WAIT_STATES);
    localparam logic [2:0] W_B  = 3'b000;
    localparam logic [2:0] W_H  = 3'b001;
    localparam logic [2:0] W_W  = 3'b010;
    localparam logic [2:0] W_BU = 3'b011;
    localparam logic [2:0] W_HU = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [3:0]     cnt;
    logic           we;
    logic [AW+1:0]  addr;
    logic [2:0]     width;
    logic [31:0]    wdata;
    logic [31:0]    mem [DEPTH_WORDS];

    logic           accept;
    logic           access;
    logic [AW-1:0]  word_idx;
    logic [1:0]     ofs;
    logic           unsupported;
    logic           misaligned;
    logic           err_flag;
    logic           suppress;
    logic [31:0]    rd_word;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic [31:0]    load_data;
    logic [3:0]     be;
    logic [31:0]    wd;
    logic           wr_en;
    logic           unused_addr;

    // The address wraps: only the bits that select a word and a lane matter.
    assign unused_addr = ^req_addr_i[31:AW+2];

    assign req_ready_o = (state == S_IDLE);
    assign rsp_valid_o = (state == S_RESP);
    assign accept      = (state == S_IDLE) && req_valid_i;
    assign access      = (state == S_WAIT) && (cnt == 4'd0);
    assign word_idx    = addr[AW+1:2];
    assign ofs         = addr[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (req_valid_i) state_next = S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_next = S_RESP;
            S_RESP:  if (rsp_ready_i) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Decode works on the latched request so the initiator may change its
    // bus once the request has been accepted.
    always_comb begin
        unsupported = (width > W_HU) || (we && ((width == W_BU) || (width == W_HU)));
        misaligned  = (((width == W_H) || (width == W_HU)) && ofs[0])
                   || ((width == W_W) && (ofs != 2'b00));
        err_flag    = unsupported || (misaligned && (MISALIGNED_ERR != 0));
        suppress    = unsupported || misaligned;
    end

    always_comb begin
        rd_word  = mem[word_idx];
        byte_sel = rd_word[7:0];
        case (ofs)
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            2'd3:    byte_sel = rd_word[31:24];
            default: byte_sel = rd_word[7:0];
        endcase
        half_sel = ofs[1] ? rd_word[31:16] : rd_word[15:0];
        case (width)
            W_B:     load_data = {{24{byte_sel[7]}}, byte_sel};
            W_BU:    load_data = {24'd0, byte_sel};
            W_H:     load_data = {{16{half_sel[15]}}, half_sel};
            W_HU:    load_data = {16'd0, half_sel};
            W_W:     load_data = rd_word;
            default: load_data = 32'd0;
        endcase
        if (we || suppress) begin
            load_data = 32'd0;
        end
    end

    always_comb begin
        be = 4'b0000;
        wd = wdata;
        case (width)
            W_B: begin
                be = 4'b0001 << ofs;
                wd = {4{wdata[7:0]}};
            end
            W_H: begin
                be = ofs[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata[15:0]}};
            end
            W_W: begin
                be = 4'b1111;
                wd = wdata;
            end
            default: be = 4'b0000;
        endcase
        wr_en = access && we && !suppress;
    end

    // RAM has no reset; a reset during WAIT leaves the FSM in IDLE before
    // the commit edge, so an aborted store never lands.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt         <= 4'd0;
            we          <= 1'b0;
            addr        <= '0;
            width       <= 3'd0;
            wdata       <= 32'd0;
            rsp_rdata_o <= 32'd0;
            rsp_err_o   <= 1'b0;
        end else begin
            if (accept) begin
                we    <= req_we_i;
                addr  <= req_addr_i[AW+1:0];
                width <= req_width_i;
                wdata <= req_wdata_i;
                cnt   <= WS;
            end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                rsp_rdata_o <= load_data;
                rsp_err_o   <= err_flag;
            end
        end
    end

endmodule

// File: tb/tb_dmem_bus_responder.sv
// tb/tb_dmem_bus_responder.sv - scoreboard bench for dmem_bus_responder
module tb_dmem_bus_responder;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b011;
    localparam logic [2:0] HU = 3'b100;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [2:0]  req_width = 3'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_ready = 1'b0;

    logic        req_valid_a, req_valid_b;
    logic        req_ready_a, req_ready_b;
    logic        rsp_valid_a, rsp_valid_b;
    logic [31:0] rsp_rdata_a, rsp_rdata_b;
    logic        rsp_err_a, rsp_err_b;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    assign req_valid_a = req_valid & ~sel;
    assign req_valid_b = req_valid & sel;
    assign req_ready   = sel ? req_ready_b : req_ready_a;
    assign rsp_valid   = sel ? rsp_valid_b : rsp_valid_a;
    assign rsp_rdata   = sel ? rsp_rdata_b : rsp_rdata_a;
    assign rsp_err     = sel ? rsp_err_b   : rsp_err_a;

    dmem_bus_responder #(.DEPTH_WORDS(128), .WAIT_STATES(2), .MISALIGNED_ERR(1)) u_ws2 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid_a), .req_ready_o(req_ready_a),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_width_i(req_width),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata_a), .rsp_err_o(rsp_err_a)
    );

    dmem_bus_responder #(.DEPTH_WORDS(128), .WAIT_STATES(0), .MISALIGNED_ERR(1)) u_ws0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid_b), .req_ready_o(req_ready_b),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_width_i(req_width),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata_b), .rsp_err_o(rsp_err_b)
    );

    task automatic xfer(input logic we, input logic [31:0] a, input logic [2:0] w,
                        input logic [31:0] d, input logic [31:0] er, input logic ee,
                        input int lat_exp, input int hold);
        exp_t e;
        int   lat;
        e.rdata = er;
        e.err   = ee;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_width = w; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 40);
        e = sb.pop_front();
        vectors++;
        if (rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rsp_timeout addr=%h: rsp_valid=%b required 1", a, rsp_valid);
            return;
        end
        if (lat_exp >= 0) begin
            vectors++;
            if (lat !== lat_exp) begin
                miscompares++;
                $display("FAIL latency addr=%h: got %0d edges required %0d", a, lat, lat_exp);
            end
        end
        vectors++;
        if (rsp_rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL rdata addr=%h width=%b: got %h required %h", a, w, rsp_rdata, e.rdata);
        end
        vectors++;
        if (rsp_err !== e.err) begin
            miscompares++;
            $display("FAIL err addr=%h width=%b: got %b required %b", a, w, rsp_err, e.err);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold cycle %0d: valid=%b rdata=%h ready=%b required 1/%h/0",
                         i, rsp_valid, rsp_rdata, req_ready, e.rdata);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL handshake addr=%h: valid=%b ready=%b rdata=%h required 0/1/%h",
                     a, rsp_valid, req_ready, rsp_rdata, e.rdata);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            vectors++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state inst=%0d: ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
                         s, req_ready, rsp_valid, rsp_rdata, rsp_err);
            end
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        xfer(1'b1, 32'h40, W, 32'hA1B2C3D4, 32'h0, 1'b0, 3, 0);
        xfer(1'b0, 32'h40, W, 32'h0, 32'hA1B2C3D4, 1'b0, 3, 0);
    endtask

    task automatic test_bytes();
        logic [7:0] pat [4] = '{8'h80, 8'h7F, 8'hAA, 8'h55};
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, 32'h64 + i, B, {24'hFFFFFF, pat[i]}, 32'h0, 1'b0, -1, 0);
        end
        xfer(1'b0, 32'h64, W,  32'h0, 32'h55AA7F80, 1'b0, -1, 0);
        xfer(1'b0, 32'h64, B,  32'h0, 32'hFFFFFF80, 1'b0, -1, 0);
        xfer(1'b0, 32'h64, BU, 32'h0, 32'h00000080, 1'b0, -1, 0);
        xfer(1'b0, 32'h65, B,  32'h0, 32'h0000007F, 1'b0, -1, 0);
        xfer(1'b0, 32'h66, B,  32'h0, 32'hFFFFFFAA, 1'b0, -1, 0);
    endtask

    task automatic test_halves();
        xfer(1'b1, 32'h40, H,  32'hDEAD8001, 32'h0, 1'b0, -1, 0);
        xfer(1'b1, 32'h42, H,  32'h00007FFF, 32'h0, 1'b0, -1, 0);
        xfer(1'b0, 32'h40, W,  32'h0, 32'h7FFF8001, 1'b0, -1, 0);
        xfer(1'b0, 32'h40, H,  32'h0, 32'hFFFF8001, 1'b0, -1, 0);
        xfer(1'b0, 32'h40, HU, 32'h0, 32'h00008001, 1'b0, -1, 0);
        xfer(1'b0, 32'h42, H,  32'h0, 32'h00007FFF, 1'b0, -1, 0);
    endtask

    task automatic test_errors();
        xfer(1'b0, 32'h41, W,      32'h0, 32'h0, 1'b1, -1, 0);
        xfer(1'b0, 32'h41, H,      32'h0, 32'h0, 1'b1, -1, 0);
        xfer(1'b1, 32'h42, W,      32'hFFFFFFFF, 32'h0, 1'b1, -1, 0);
        xfer(1'b1, 32'h41, H,      32'hFFFFFFFF, 32'h0, 1'b1, -1, 0);
        xfer(1'b1, 32'h40, BU,     32'hFFFFFFFF, 32'h0, 1'b1, -1, 0);
        xfer(1'b0, 32'h40, W,      32'h0, 32'h7FFF8001, 1'b0, -1, 0);
        xfer(1'b0, 32'h40, 3'b101, 32'h0, 32'h0, 1'b1, -1, 0);
        xfer(1'b0, 32'h40, 3'b111, 32'h0, 32'h0, 1'b1, -1, 0);
        // Address wrap: 128 words, so 0x240 aliases 0x40.
        xfer(1'b0, 32'h240, W,     32'h0, 32'h7FFF8001, 1'b0, -1, 0);
    endtask

    task automatic test_backpressure();
        xfer(1'b0, 32'h64, W, 32'h0, 32'h55AA7F80, 1'b0, 3, 5);
        sel = 1'b1;
        xfer(1'b1, 32'h10, W, 32'hCAFEF00D, 32'h0, 1'b0, 1, 0);
        xfer(1'b0, 32'h10, W, 32'h0, 32'hCAFEF00D, 1'b0, 1, 5);
        xfer(1'b0, 32'h13, BU, 32'h0, 32'h000000CA, 1'b0, 1, 0);
        sel = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        xfer(1'b1, 32'h80, W, 32'h11111111, 32'h0, 1'b0, -1, 0);
        xfer(1'b0, 32'h80, W, 32'h0, 32'h11111111, 1'b0, -1, 0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h80; req_width = W; req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        vectors++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_entry: ready=%b valid=%b required 0/0", req_ready, rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_wait: ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 32'h80, W, 32'h0, 32'h11111111, 1'b0, 3, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, miscompares=%0d required 0", miscompares);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word();
        test_bytes();
        test_halves();
        test_errors();
        test_backpressure();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
